// File: rtl/ofmap_wr_pkg.sv
// Shared types and constants for the output-feature-map writeback engine.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ofmap_wr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      AW,
      W,
      B
   } wr_state_e;

   localparam logic [1:0] AXI_INCR = 2'b01;
   localparam logic [1:0] AXI_OKAY = 2'b00;

   // Byte stride of one pixel for a given data width.
   function automatic int bytes_of(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Result FIFO between the PE array and the AXI write channel, with occupancy count.
// Latency: a pushed word is visible on rd_data the cycle after the push (show-ahead read).
// Backpressure: pushes are dropped while full, pops are ignored while empty.
module wb_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DW-1:0]            push_data,
   input  logic                     pop,
   output logic [DW-1:0]            rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Storage array: written on accepted pushes only, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ofmap_wr_ctrl.sv
// Output-feature-map writeback: buffers PE results and writes one tile row per AXI INCR burst (optional WB_RELU_EN clamps negatives on wdata).
// Latency: AW issued the cycle after a full tile row is buffered; one outstanding burst, next AW no earlier than the cycle after bvalid.
// Backpressure: res_ready drops when the FIFO is full; awvalid/wvalid hold their payload stable until awready/wready.
module ofmap_wr_ctrl #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int POX        = 15,
   parameter int POY        = 3,
   parameter int OW         = 112,
   parameter int OH         = 112,
   parameter int FIFO_DEPTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] init_addr,
   input  logic          init_addr_en,
   input  logic          res_valid,
   input  logic [DW-1:0] res_data,
   output logic          res_ready,
   output logic [AW-1:0] awaddr,
   output logic [7:0]    awlen,
   output logic [1:0]    awburst,
   output logic          awvalid,
   input  logic          awready,
   output logic [DW-1:0] wdata,
   output logic          wlast,
   output logic          wvalid,
   input  logic          wready,
   input  logic [1:0]    bresp,
   input  logic          bvalid,
   output logic          bready,
   output logic          busy,
   output logic          mapend,
   output logic          wr_err
);
   import ofmap_wr_pkg::*;

   localparam logic [31:0] BYTES_U = 32'(bytes_of(DW));
   localparam logic [31:0] OW_U    = 32'(OW);
   localparam logic [31:0] OH_U    = 32'(OH);
   localparam logic [31:0] POX_U   = 32'(POX);
   localparam logic [31:0] POY_U   = 32'(POY);
   localparam int          CNTW    = $clog2(FIFO_DEPTH) + 1;

   wr_state_e        state, state_nxt;
   logic [AW-1:0]    base;
   logic [31:0]      col, row, ty, beat;
   logic [31:0]      blen, rows_in_tile, pix_off, col_nxt, row_nxt;
   logic [AW-1:0]    addr;
   logic             last_ty, col_wrap, map_done;

   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DW-1:0]    fifo_dout;
   logic [CNTW-1:0]  fifo_count;

   assign fifo_push = res_valid && !fifo_full;
   assign fifo_pop  = wvalid && wready;
   assign res_ready = !fifo_full;
   assign awburst   = AXI_INCR;
   assign busy      = (state != IDLE);

   wb_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (res_data),
      .pop       (fifo_pop),
      .rd_data   (fifo_dout),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Tile geometry, burst address and position-advance decisions for the current tile row.
   always_comb begin
      blen         = ((OW_U - col) < POX_U) ? (OW_U - col) : POX_U;
      rows_in_tile = ((OH_U - row) < POY_U) ? (OH_U - row) : POY_U;
      pix_off      = ((row + ty) * OW_U + col) * BYTES_U;
      addr         = base + AW'(pix_off);
      col_nxt      = col + POX_U;
      row_nxt      = row + POY_U;
      last_ty      = (ty == rows_in_tile - 32'd1);
      col_wrap     = (col_nxt >= OW_U);
      map_done     = last_ty && col_wrap && (row_nxt >= OH_U);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and channel handshake outputs.
   always_comb begin
      state_nxt = state;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      wlast     = 1'b0;
      bready    = 1'b0;
      case (state)
         IDLE: if (init_addr_en) state_nxt = WAIT;
         WAIT: if (32'(fifo_count) >= blen) state_nxt = ofmap_wr_pkg::AW;
         ofmap_wr_pkg::AW: begin
            awvalid = 1'b1;
            if (awready) state_nxt = W;
         end
         W: begin
            wvalid = !fifo_empty;
            wlast  = !fifo_empty && (beat == blen - 32'd1);
            if (fifo_pop && wlast) state_nxt = B;
         end
         B: begin
            bready = 1'b1;
            if (bvalid) state_nxt = map_done ? IDLE : WAIT;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Write data is driven as zero whenever no beat is offered, so idle/reset wdata is clean.
   always_comb begin
`ifdef WB_RELU_EN
      wdata = (wvalid && !fifo_dout[DW-1]) ? fifo_dout : '0;
`else
      wdata = wvalid ? fifo_dout : '0;
`endif
   end

   // Map position, burst command registers, error flag and end-of-map pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base   <= '0;
         col    <= '0;
         row    <= '0;
         ty     <= '0;
         beat   <= '0;
         awaddr <= '0;
         awlen  <= '0;
         wr_err <= 1'b0;
         mapend <= 1'b0;
      end else begin
         mapend <= 1'b0;
         case (state)
            IDLE: if (init_addr_en) begin
               base   <= init_addr;
               wr_err <= 1'b0;
               col    <= '0;
               row    <= '0;
               ty     <= '0;
            end
            WAIT: if (state_nxt == ofmap_wr_pkg::AW) begin
               awaddr <= addr;
               awlen  <= 8'(blen - 32'd1);
               beat   <= '0;
            end
            W: if (fifo_pop) beat <= beat + 32'd1;
            B: if (bvalid) begin
               if (bresp != AXI_OKAY) wr_err <= 1'b1;
               if (!last_ty) begin
                  ty <= ty + 32'd1;
               end else begin
                  ty <= '0;
                  if (col_wrap) begin
                     col <= '0;
                     row <= row_nxt;
                  end else begin
                     col <= col_nxt;
                  end
               end
               mapend <= map_done;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ofmap_wr_ctrl.sv
// Bench for ofmap_wr_ctrl on a 20x4 map with 15x3 tiles (full and partial tile columns/rows).
// Latency: checks AW timing against FIFO fill and bvalid, beat order against a word scoreboard.
// Backpressure: exercises awready/wready/bvalid stalls, an error response and a mid-burst reset.
module tb_ofmap_wr_ctrl;
   localparam int NWORDS = 80;
   localparam int NB     = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] init_addr;
   logic        init_addr_en;
   logic        res_valid;
   logic [31:0] res_data;
   logic        res_ready;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic        busy;
   logic        mapend;
   logic        wr_err;

   always #5 clk = ~clk;

   ofmap_wr_ctrl #(
      .AW(32), .DW(32), .POX(15), .POY(3), .OW(20), .OH(4), .FIFO_DEPTH(32)
   ) dut (
      .clk(clk), .rst_n(rst_n), .init_addr(init_addr), .init_addr_en(init_addr_en),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .busy(busy), .mapend(mapend), .wr_err(wr_err)
   );

   typedef struct {
      int          aw_stall;
      logic        w_rand;
      int          b_delay;
      logic [1:0]  bresp;
      logic [31:0] exp_addr;
      logic [7:0]  exp_len;
      logic        exp_err;
   } vec_t;

   vec_t vecs [NB];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   push_idx = 0;
   int   push_lim = 0;
   int   widx = 0;

   function automatic logic [31:0] stream_word(input int i);
      if (i == 0) return 32'hFFFF_FFF0;
      if (i == 1) return 32'h0000_0010;
      return 32'h100 + 32'(i);
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [31:0] v);
`ifdef WB_RELU_EN
      return v[31] ? 32'h0 : v;
`else
      return v;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_to(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_init(input logic [31:0] a);
      init_addr    = a;
      init_addr_en = 1'b1;
      step();
      init_addr_en = 1'b0;
   endtask

   // Upstream producer: offers stream words up to push_lim; ready seen at the negedge holds until the next posedge.
   initial begin : producer
      logic pend;
      pend      = 1'b0;
      res_valid = 1'b0;
      res_data  = '0;
      forever begin
         @(negedge clk);
         if (pend) push_idx++;
         if (push_idx < push_lim) begin
            res_valid = 1'b1;
            res_data  = stream_word(push_idx);
         end else begin
            res_valid = 1'b0;
            res_data  = '0;
         end
         pend = res_valid && res_ready;
      end
   end

   task automatic run_map();
      for (int i = 0; i < NB; i++) begin
         int cyc;
         int b;
         int len;
         len = int'(vecs[i].exp_len);
         if (i == 4) pulse_init(32'h9000);
         cyc = 0;
         while (!awvalid && cyc < 200) begin
            step();
            cyc++;
         end
         if (!awvalid) fail_to($sformatf("aw_wait[%0d]", i));
         for (int s = 0; s <= vecs[i].aw_stall; s++) begin
            chk($sformatf("awvalid[%0d]", i), awvalid, 1'b1);
            chk($sformatf("awaddr[%0d]", i), awaddr, vecs[i].exp_addr);
            chk($sformatf("awlen[%0d]", i), awlen, vecs[i].exp_len);
            chk($sformatf("wvalid_pre_aw[%0d]", i), wvalid, 1'b0);
            awready = (s == vecs[i].aw_stall);
            step();
         end
         awready = 1'b0;
         chk($sformatf("awburst[%0d]", i), awburst, 2'b01);
         b   = 0;
         cyc = 0;
         while (b <= len && cyc < 500) begin
            wready = vecs[i].w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wvalid) begin
               chk($sformatf("wdata[%0d.%0d]", i, b), wdata, exp_wdata(stream_word(widx)));
               chk($sformatf("wlast[%0d.%0d]", i, b), wlast, (b == len));
               if (wready) begin
                  b++;
                  widx++;
               end
            end
            step();
            cyc++;
         end
         wready = 1'b0;
         if (b <= len) fail_to($sformatf("w_beats[%0d]", i));
         chk($sformatf("bready[%0d]", i), bready, 1'b1);
         chk($sformatf("wvalid_in_b[%0d]", i), wvalid, 1'b0);
         repeat (vecs[i].b_delay) begin
            step();
            chk($sformatf("bready_hold[%0d]", i), bready, 1'b1);
            chk($sformatf("awvalid_b_stall[%0d]", i), awvalid, 1'b0);
         end
         bvalid = 1'b1;
         bresp  = vecs[i].bresp;
         step();
         bvalid = 1'b0;
         bresp  = 2'b00;
         chk($sformatf("wr_err[%0d]", i), wr_err, vecs[i].exp_err);
         chk($sformatf("awvalid_after_b[%0d]", i), awvalid, 1'b0);
         chk($sformatf("mapend[%0d]", i), mapend, (i == NB - 1));
         chk($sformatf("busy[%0d]", i), busy, (i != NB - 1));
      end
      step();
      chk("mapend_pulse_end", mapend, 1'b0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_awvalid"}, awvalid, 1'b0);
      chk({tag, "_wvalid"}, wvalid, 1'b0);
      chk({tag, "_wlast"}, wlast, 1'b0);
      chk({tag, "_bready"}, bready, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_mapend"}, mapend, 1'b0);
      chk({tag, "_wr_err"}, wr_err, 1'b0);
      chk({tag, "_awaddr"}, awaddr, 32'h0);
      chk({tag, "_awlen"}, awlen, 8'h0);
      chk({tag, "_wdata"}, wdata, 32'h0);
      chk({tag, "_awburst"}, awburst, 2'b01);
      chk({tag, "_res_ready"}, res_ready, 1'b1);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int cyc;
      int beats;
      //         aw_stall w_rand b_delay bresp  addr          len    err
      vecs[0] = '{0, 1'b0, 0, 2'b00, 32'h0000_1000, 8'd14, 1'b0};
      vecs[1] = '{2, 1'b1, 1, 2'b00, 32'h0000_1050, 8'd14, 1'b0};
      vecs[2] = '{0, 1'b1, 3, 2'b10, 32'h0000_10A0, 8'd14, 1'b1};
      vecs[3] = '{1, 1'b0, 0, 2'b00, 32'h0000_103C, 8'd4,  1'b1};
      vecs[4] = '{3, 1'b1, 2, 2'b00, 32'h0000_108C, 8'd4,  1'b1};
      vecs[5] = '{0, 1'b0, 0, 2'b00, 32'h0000_10DC, 8'd4,  1'b1};
      vecs[6] = '{1, 1'b1, 1, 2'b00, 32'h0000_10F0, 8'd14, 1'b1};
      vecs[7] = '{0, 1'b1, 0, 2'b00, 32'h0000_112C, 8'd4,  1'b1};

      rst_n        = 1'b0;
      init_addr    = '0;
      init_addr_en = 1'b0;
      awready      = 1'b0;
      wready       = 1'b0;
      bresp        = 2'b00;
      bvalid       = 1'b0;
      repeat (3) step();
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      step();

      // Map 1: start, then starve the FIFO one word short of a burst.
      pulse_init(32'h0000_1000);
      chk("busy_after_init", busy, 1'b1);
      push_lim = 14;
      repeat (30) step();
      chk("awvalid_short_fifo", awvalid, 1'b0);
      chk("busy_waiting", busy, 1'b1);
      push_lim = 15;
      cyc = 0;
      while (push_idx < 15 && cyc < 50) begin
         chk("awvalid_before_15th", awvalid, 1'b0);
         step();
         cyc++;
      end
      if (push_idx < 15) fail_to("push_15th");
      chk("awvalid_after_15th", awvalid, 1'b1);
      push_lim = NWORDS;
      widx     = 0;
      run_map();
      chk("wr_err_after_map1", wr_err, 1'b1);

      // Map 2: init clears the error, then reset lands on beat 7 of the first burst.
      push_idx = 0;
      push_lim = NWORDS;
      widx     = 0;
      pulse_init(32'h0000_1000);
      chk("wr_err_cleared_by_init", wr_err, 1'b0);
      chk("busy_map2", busy, 1'b1);
      cyc = 0;
      while (!awvalid && cyc < 200) begin
         step();
         cyc++;
      end
      if (!awvalid) fail_to("aw_wait_map2");
      awready = 1'b1;
      step();
      awready = 1'b0;
      wready  = 1'b1;
      beats   = 0;
      cyc     = 0;
      while (beats < 7 && cyc < 200) begin
         if (wvalid) beats++;
         step();
         cyc++;
      end
      if (beats < 7) fail_to("beats_map2");
      chk("beat7_offered", wvalid, 1'b1);
      push_lim = 0;
      rst_n    = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      wready = 1'b0;
      repeat (3) step();
      push_idx = 0;
      rst_n    = 1'b1;
      step();

      // Map 3: full restart after the abandoned burst.
      push_lim = NWORDS;
      widx     = 0;
      pulse_init(32'h0000_1000);
      run_map();
      chk("wr_err_after_map3", wr_err, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
